// File: rtl/reg_sched_pkg.sv
// Shared widths, constants and the write-back entry type for the register write-back scheduler.
package reg_sched_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// Small synchronous FIFO holding mul/div results until the register file write port is free.
module md_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage; reset discards any queued results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Shares the register file write port between the WB stage (always wins) and queued mul/div
// results, and tracks registers with an outstanding mul/div result to stall dependent reads.
module reg_wb_sched #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_issue_addr,
  output logic              issue_stall,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic              rd_stall,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data
);

  import reg_sched_pkg::*;

  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] REG0 = ADDR_W'(ZERO_REG);

  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              pop;
  logic              issue_set;

  assign head_addr = head[ENT_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  // Readiness comes from the registered count only, so md_valid never feeds md_ready.
  assign md_ready  = (fifo_count < CNT_W'(BUF_DEPTH));
  assign push      = md_valid & md_ready & ~fifo_full;
  assign pop       = ~pipe_wr & ~fifo_empty;

  assign issue_stall = pending_q[md_issue_addr];
  assign issue_set   = md_issue & ~issue_stall & (md_issue_addr != REG0);
  assign rd_stall    = ((r1_addr != REG0) & pending_q[r1_addr]) |
                       ((r2_addr != REG0) & pending_q[r2_addr]);

  md_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({md_addr, md_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write port mux: pipeline first, then FIFO head; commits to register 0 are suppressed.
  always_comb begin
    rf_wr      = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (pipe_wr) begin
      rf_wr      = (pipe_addr != REG0);
      rf_wr_addr = pipe_addr;
      rf_wr_data = pipe_data;
    end else if (!fifo_empty) begin
      rf_wr      = (head_addr != REG0);
      rf_wr_addr = head_addr;
      rf_wr_data = head_data;
    end
  end

  // Scoreboard next state: the head commit clears first, then a new issue may set.
  always_comb begin
    pending_d = pending_q;
    if (pop)       pending_d[head_addr]     = 1'b0;
    if (issue_set) pending_d[md_issue_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed and randomized checks of reg_wb_sched against a queue/array reference model.
module tb_reg_wb_sched;

  import reg_sched_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_wr;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              md_issue;
  logic [ADDR_W-1:0] md_issue_addr;
  logic              issue_stall;
  logic              md_valid;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic [ADDR_W-1:0] r2_addr;
  logic              rd_stall;
  logic              rf_wr;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued results in order, and the set of registers awaiting a result.
  wb_entry_t q[$];
  bit        pend [32];

  always #5 clk = ~clk;

  reg_wb_sched #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wr       (pipe_wr),
    .pipe_addr     (pipe_addr),
    .pipe_data     (pipe_data),
    .md_issue      (md_issue),
    .md_issue_addr (md_issue_addr),
    .issue_stall   (issue_stall),
    .md_valid      (md_valid),
    .md_addr       (md_addr),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .r1_addr       (r1_addr),
    .r2_addr       (r2_addr),
    .rd_stall      (rd_stall),
    .rf_wr         (rf_wr),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_wr = 1'b0; pipe_addr = '0; pipe_data = '0;
    md_issue = 1'b0; md_issue_addr = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    r1_addr = '0; r2_addr = '0;
  endtask

  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
  endtask

  // Check all outputs against the model for the current inputs, then advance one clock.
  task automatic step();
    bit                e_ready, e_wr, e_stall, e_rd, do_pop;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    wb_entry_t         h;
    #1;
    chk("pipe_wr_to_pending", 32'(pipe_wr & pend[pipe_addr]), 32'd0);
    e_ready = (q.size() < DEPTH);
    e_stall = pend[md_issue_addr];
    e_rd    = (r1_addr != 0 && pend[r1_addr]) || (r2_addr != 0 && pend[r2_addr]);
    do_pop  = 1'b0;
    e_wr = 1'b0; e_addr = '0; e_data = '0;
    h = '0;
    if (pipe_wr) begin
      e_wr = (pipe_addr != 0); e_addr = pipe_addr; e_data = pipe_data;
    end else if (q.size() != 0) begin
      h = q[0];
      do_pop = 1'b1;
      e_wr = (h.addr != 0); e_addr = h.addr; e_data = h.data;
    end
    chk("md_ready", 32'(md_ready), 32'(e_ready));
    chk("issue_stall", 32'(issue_stall), 32'(e_stall));
    chk("rd_stall", 32'(rd_stall), 32'(e_rd));
    chk("rf_wr", 32'(rf_wr), 32'(e_wr));
    chk("rf_wr_addr", 32'(rf_wr_addr), 32'(e_addr));
    chk("rf_wr_data", 32'(rf_wr_data), 32'(e_data));
    @(posedge clk);
    if (do_pop) begin
      pend[h.addr] = 1'b0;
      void'(q.pop_front());
    end
    if (md_issue && !e_stall && md_issue_addr != 0) pend[md_issue_addr] = 1'b1;
    if (md_valid && e_ready) q.push_back(wb_entry_t'{addr: md_addr, data: md_data});
    @(negedge clk);
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_md_ready", 32'(md_ready), 32'd1);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("rst_rf_wr_data", rf_wr_data, 32'd0);
    chk("rst_issue_stall", 32'(issue_stall), 32'd0);
    for (int i = 0; i < 32; i++) begin
      r1_addr = ADDR_W'(i);
      r2_addr = ADDR_W'(31 - i);
      #1;
      chk("rst_rd_stall", 32'(rd_stall), 32'd0);
      step();
    end

    // Basic mul/div write-back
    idle();
    md_issue = 1'b1; md_issue_addr = 5'd5;
    #1 chk("basic_issue_stall", 32'(issue_stall), 32'd0);
    step();
    md_issue = 1'b0; r1_addr = 5'd5;
    #1 chk("basic_rd_stall_pending", 32'(rd_stall), 32'd1);
    step();
    step();
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'hDEADBEEF;
    #1 chk("basic_md_ready", 32'(md_ready), 32'd1);
    step();
    md_valid = 1'b0;
    #1;
    chk("basic_rf_wr", 32'(rf_wr), 32'd1);
    chk("basic_rf_wr_addr", 32'(rf_wr_addr), 32'd5);
    chk("basic_rf_wr_data", rf_wr_data, 32'hDEADBEEF);
    chk("basic_rd_stall_commit", 32'(rd_stall), 32'd1);
    step();
    #1;
    chk("basic_rd_stall_clear", 32'(rd_stall), 32'd0);
    chk("basic_rf_wr_idle", 32'(rf_wr), 32'd0);
    step();

    // Pipeline priority and backpressure
    idle();
    pipe_wr = 1'b1; pipe_addr = 5'd7; pipe_data = 32'h11;
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h22;
    #1 chk("prio_addr_c1", 32'(rf_wr_addr), 32'd7);
    step();
    md_addr = 5'd9; md_data = 32'h33;
    #1 chk("prio_ready_c2", 32'(md_ready), 32'd1);
    step();
    md_valid = 1'b0;
    #1;
    chk("prio_ready_full", 32'(md_ready), 32'd0);
    chk("prio_addr_c3", 32'(rf_wr_addr), 32'd7);
    chk("prio_data_c3", rf_wr_data, 32'h11);
    step();
    #1 chk("prio_ready_c4", 32'(md_ready), 32'd0);
    step();
    pipe_wr = 1'b0;
    md_valid = 1'b1; md_addr = 5'd12; md_data = 32'h44;
    #1;
    chk("prio_drain1_wr", 32'(rf_wr), 32'd1);
    chk("prio_drain1_addr", 32'(rf_wr_addr), 32'd8);
    chk("prio_drain1_data", rf_wr_data, 32'h22);
    chk("prio_full_pop_ready", 32'(md_ready), 32'd0);
    step();
    md_valid = 1'b0;
    #1;
    chk("prio_drain2_addr", 32'(rf_wr_addr), 32'd9);
    chk("prio_drain2_data", rf_wr_data, 32'h33);
    chk("prio_drain2_ready", 32'(md_ready), 32'd1);
    step();
    #1 chk("prio_empty_wr", 32'(rf_wr), 32'd0);
    step();

    // WAW protection
    idle();
    md_issue = 1'b1; md_issue_addr = 5'd3;
    #1 chk("waw_first", 32'(issue_stall), 32'd0);
    step();
    #1 chk("waw_second", 32'(issue_stall), 32'd1);
    step();
    md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h333;
    #1 chk("waw_accept", 32'(issue_stall), 32'd1);
    step();
    md_valid = 1'b0;
    #1;
    chk("waw_commit_stall", 32'(issue_stall), 32'd1);
    chk("waw_commit_addr", 32'(rf_wr_addr), 32'd3);
    step();
    #1 chk("waw_released", 32'(issue_stall), 32'd0);
    step();
    md_issue = 1'b0;
    md_valid = 1'b1; md_data = 32'h334;
    step();
    md_valid = 1'b0;
    step();
    step();

    // Register 0
    idle();
    md_issue = 1'b1; md_issue_addr = 5'd0;
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hFFFF;
    #1;
    chk("r0_issue_stall", 32'(issue_stall), 32'd0);
    chk("r0_rd_stall_a", 32'(rd_stall), 32'd0);
    step();
    md_issue = 1'b0;
    md_addr = 5'd6; md_data = 32'h66;
    #1;
    chk("r0_rf_wr", 32'(rf_wr), 32'd0);
    chk("r0_rd_stall_b", 32'(rd_stall), 32'd0);
    step();
    md_valid = 1'b0;
    #1;
    chk("r0_popped_wr", 32'(rf_wr), 32'd1);
    chk("r0_popped_addr", 32'(rf_wr_addr), 32'd6);
    chk("r0_popped_data", rf_wr_data, 32'h66);
    step();

    // Reset with a full FIFO
    idle();
    md_issue = 1'b1; md_issue_addr = 5'd10;
    step();
    md_issue_addr = 5'd11;
    step();
    md_issue = 1'b0;
    pipe_wr = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h1;
    md_valid = 1'b1; md_addr = 5'd10; md_data = 32'hA;
    step();
    md_addr = 5'd11; md_data = 32'hB;
    step();
    md_valid = 1'b0;
    #1 chk("rstfull_ready", 32'(md_ready), 32'd0);
    step();
    pipe_wr = 1'b0; r1_addr = 5'd11; md_issue_addr = 5'd11;
    #1 chk("rstfull_drain_addr", 32'(rf_wr_addr), 32'd10);
    step();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstfull_rf_wr", 32'(rf_wr), 32'd0);
    chk("rstfull_md_ready", 32'(md_ready), 32'd1);
    chk("rstfull_rd_stall", 32'(rd_stall), 32'd0);
    chk("rstfull_issue_stall", 32'(issue_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstfull_no_commit1", 32'(rf_wr), 32'd0);
    step();
    #1 chk("rstfull_no_commit2", 32'(rf_wr), 32'd0);
    step();

    // Randomized traffic against the model
    repeat (400) begin
      pipe_wr       = 1'($urandom_range(0, 1));
      pipe_addr     = ADDR_W'($urandom);
      pipe_data     = $urandom;
      if (pend[pipe_addr]) pipe_wr = 1'b0;
      md_issue      = ($urandom_range(0, 3) == 0);
      md_issue_addr = ADDR_W'($urandom);
      md_valid      = 1'($urandom_range(0, 1));
      md_addr       = ADDR_W'($urandom);
      md_data       = $urandom;
      r1_addr       = ADDR_W'($urandom);
      r2_addr       = ADDR_W'($urandom);
      step();
    end
    idle();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
